// File: rtl/gpu_pkg.sv
// gpu_pkg: shared widths, triangle word counts and fetch FSM states
package gpu_pkg;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_COORD_WIDTH = 16;
  localparam int DEF_COLOR_WIDTH = 16;
  localparam int VERTEX_COUNT = 3;
  localparam int COORD_COUNT = 3;
  localparam int TRI_WORDS = 10;
  localparam int K_WIDTH = $clog2(TRI_WORDS);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;
endpackage

// File: rtl/data_fetch_addr_gen.sv
// data_fetch_addr_gen: read address for word k; vertex words stride from base, last word is color
module data_fetch_addr_gen
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int COORD_WIDTH = DEF_COORD_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] base_vertex,
  input  logic [ADDR_WIDTH-1:0] base_color,
  input  logic [K_WIDTH-1:0]    k,
  output logic [ADDR_WIDTH-1:0] addr
);
  localparam int BYTES = COORD_WIDTH / 8;
  // sum is truncated to ADDR_WIDTH, so wrap past all-ones is silent
  always_comb addr = (k == K_WIDTH'(TRI_WORDS - 1)) ? base_color
                   : base_vertex + ADDR_WIDTH'(k) * ADDR_WIDTH'(BYTES);
endmodule

// File: rtl/data_fetch.sv
// data_fetch: fetches 9 coordinate words and 1 color word per fetch_start; DATA_FETCH_STALL_CNT_EN adds stall_cycles
module data_fetch
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int COORD_WIDTH = DEF_COORD_WIDTH,
  parameter int COLOR_WIDTH = DEF_COLOR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_start,
  input  logic [ADDR_WIDTH-1:0]  curr_addr_vertex,
  input  logic [ADDR_WIDTH-1:0]  curr_addr_color,
  output logic [COORD_WIDTH-1:0] fetch_vertexes [VERTEX_COUNT][COORD_COUNT],
  output logic [COLOR_WIDTH-1:0] fetch_color,
  output logic                   fetch_eoc,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic                   mem_read,
  input  logic                   mem_waitrequest,
  input  logic [COORD_WIDTH-1:0] mem_readdata,
  input  logic                   mem_readdatavalid
`ifdef DATA_FETCH_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);
  fetch_state_t          state;
  logic [K_WIDTH-1:0]    k;
  logic [ADDR_WIDTH-1:0] base_vertex;
  logic [ADDR_WIDTH-1:0] base_color;

  data_fetch_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .COORD_WIDTH(COORD_WIDTH)) u_addr_gen (
    .base_vertex(base_vertex),
    .base_color(base_color),
    .k(k),
    .addr(mem_address)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      mem_read <= 1'b0;
      base_vertex <= '0;
      base_color <= '0;
      fetch_color <= '0;
      fetch_eoc <= 1'b1;
      for (int v = 0; v < VERTEX_COUNT; v++)
        for (int c = 0; c < COORD_COUNT; c++)
          fetch_vertexes[v][c] <= '0;
    end else begin
      case (state)
        IDLE: if (fetch_start) begin
          base_vertex <= curr_addr_vertex;
          base_color <= curr_addr_color;
          k <= '0;
          mem_read <= 1'b1;
          fetch_eoc <= 1'b0;
          state <= REQ;
        end
        REQ: if (!mem_waitrequest) begin
          mem_read <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (mem_readdatavalid) begin
          for (int v = 0; v < VERTEX_COUNT; v++)
            for (int c = 0; c < COORD_COUNT; c++)
              if (k == K_WIDTH'(v * COORD_COUNT + c)) fetch_vertexes[v][c] <= mem_readdata;
          if (k == K_WIDTH'(TRI_WORDS - 1)) begin
            fetch_color <= mem_readdata[COLOR_WIDTH-1:0];
            fetch_eoc <= 1'b1;
            state <= IDLE;
          end else begin
            k <= k + 1'b1;
            mem_read <= 1'b1;
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DATA_FETCH_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cycles <= '0;
    else if (state == IDLE && fetch_start) stall_cycles <= '0;
    else if (((state == REQ && mem_waitrequest) || (state == WAIT && !mem_readdatavalid)) && stall_cycles != '1)
      stall_cycles <= stall_cycles + 1'b1;
  end
`endif
endmodule

// File: tb/tb_data_fetch.sv
// tb_data_fetch: scoreboard bench; memory model checks read addresses, monitor checks completed triangles
module tb_data_fetch;
  logic        clk;
  logic        reset;
  logic        fetch_start;
  logic [31:0] curr_addr_vertex;
  logic [31:0] curr_addr_color;
  logic [15:0] fv [3][3];
  logic [15:0] fetch_color;
  logic        fetch_eoc;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [15:0] mem_readdata;
  logic        mem_readdatavalid;
`ifdef DATA_FETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  typedef struct {
    logic [143:0] v;
    logic [15:0]  c;
    int           start;
    int           lat;
  } res_t;

  logic [31:0] exp_addr [$];
  res_t        exp_res [$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int wait_cfg = 0;
  int rd_idx = 0;
  int rd_base = 0;
  int inject_req = 0;
  int inject_done = 0;

  data_fetch dut (
    .clk(clk),
    .reset(reset),
    .fetch_start(fetch_start),
    .curr_addr_vertex(curr_addr_vertex),
    .curr_addr_color(curr_addr_color),
    .fetch_vertexes(fv),
    .fetch_color(fetch_color),
    .fetch_eoc(fetch_eoc),
    .mem_address(mem_address),
    .mem_read(mem_read),
    .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid)
`ifdef DATA_FETCH_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [143:0] pack_fv();
    logic [143:0] p = '0;
    for (int v = 0; v < 3; v++)
      for (int c = 0; c < 3; c++)
        p[(v*3+c)*16 +: 16] = fv[v][c];
    return p;
  endfunction

  // memory: stalls wait_cfg cycles per request, returns 0x100+k one cycle after acceptance
  initial begin
    int stall_left;
    bit pend, held;
    logic [15:0] pend_data;
    logic [31:0] held_addr;
    stall_left = 0; pend = 0; held = 0; pend_data = 0; held_addr = 0;
    mem_waitrequest = 0; mem_readdatavalid = 0; mem_readdata = 0;
    forever begin
      @(negedge clk);
      mem_readdatavalid = 0;
      if (reset) begin
        pend = 0; held = 0; mem_waitrequest = 0; stall_left = wait_cfg;
      end else begin
        if (pend) begin
          mem_readdatavalid = 1; mem_readdata = pend_data; pend = 0;
        end else if (inject_req != inject_done) begin
          mem_readdatavalid = 1; mem_readdata = 16'hDEAD; inject_done = inject_req;
        end
        if (held) begin
          chk("stall_read_held", mem_read, 1'b1);
          chk("stall_addr_held", mem_address, held_addr);
        end
        held = 0;
        if (mem_read) begin
          if (stall_left > 0) begin
            mem_waitrequest = 1; stall_left--; held = 1; held_addr = mem_address;
          end else begin
            mem_waitrequest = 0; pend = 1; pend_data = 16'h100 + 16'(rd_idx - rd_base);
            rd_idx++; stall_left = wait_cfg;
            if (exp_addr.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL read_addr: unexpected read at %0h, no read required", mem_address);
            end else chk("read_addr", mem_address, exp_addr.pop_front());
          end
        end else begin
          mem_waitrequest = 0; stall_left = wait_cfg;
        end
      end
    end
  end

  // completion monitor: each fetch_eoc rise pops one expected triangle
  initial begin
    res_t r;
    logic prev_eoc;
    prev_eoc = 1;
    forever begin
      @(negedge clk);
      if (fetch_eoc && !prev_eoc && !reset) begin
        if (exp_res.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL eoc_rise: got completion, expected none pending");
        end else begin
          r = exp_res.pop_front();
          chk("vertexes", pack_fv(), r.v);
          chk("color", fetch_color, r.c);
          chk("latency", 160'(cyc - r.start), 160'(r.lat));
        end
      end
      prev_eoc = fetch_eoc;
    end
  end

  task automatic launch(input logic [31:0] bv, input logic [31:0] bc);
    res_t r;
    @(negedge clk);
    curr_addr_vertex = bv;
    curr_addr_color = bc;
    fetch_start = 1;
    rd_base = rd_idx;
    for (int k = 0; k < 9; k++) begin
      exp_addr.push_back(bv + 32'(2 * k));
      r.v[k*16 +: 16] = 16'h100 + 16'(k);
    end
    exp_addr.push_back(bc);
    r.c = 16'h109;
    r.start = cyc + 1;
    r.lat = 20 + 10 * wait_cfg;
    exp_res.push_back(r);
    @(negedge clk);
    fetch_start = 0;
  endtask

  task automatic wait_done(input string name);
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      done = (exp_res.size() == 0) && fetch_eoc;
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got no completion within 2000 cycles, expected completion", name);
    end
  endtask

  initial begin
    reset = 1; fetch_start = 0; curr_addr_vertex = 0; curr_addr_color = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    // 1: idle after reset
    repeat (5) @(posedge clk);
    #1;
    chk("rst_eoc", fetch_eoc, 1'b1);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_vertexes", pack_fv(), 144'h0);
    chk("rst_color", fetch_color, 16'h0);
`ifdef DATA_FETCH_STALL_CNT_EN
    chk("rst_stall", stall_cycles, 32'h0);
`endif
    // 2: zero-wait fetch
    launch(32'h1000, 32'h2000);
    wait_done("t2");
    chk("t2_v12", fv[1][2], 16'h105);
    chk("t2_color", fetch_color, 16'h109);
`ifdef DATA_FETCH_STALL_CNT_EN
    chk("t2_stall", stall_cycles, 32'd0);
`endif
    // 3: three stall cycles per request
    wait_cfg = 3;
    launch(32'h1000, 32'h2000);
    wait_done("t3");
    chk("t3_v12", fv[1][2], 16'h105);
`ifdef DATA_FETCH_STALL_CNT_EN
    chk("t3_stall", stall_cycles, 32'd30);
`endif
    wait_cfg = 0;
    // 4: vertex address wrap
    launch(32'hFFFFFFFC, 32'h3000);
    wait_done("t4");
    // 5: pulses while busy, including the cycle fetch_eoc rises
    launch(32'h4000, 32'h4100);
    repeat (2) @(negedge clk);
    curr_addr_vertex = 32'h7000; curr_addr_color = 32'h7100; fetch_start = 1;
    @(negedge clk);
    fetch_start = 0;
    repeat (16) @(negedge clk);
    fetch_start = 1;
    @(negedge clk);
    fetch_start = 0;
    wait_done("t5");
    repeat (5) @(negedge clk);
    chk("t5_read_count", 160'(rd_idx - rd_base), 160'(10));
    chk("t5_addr_left", 160'(exp_addr.size()), 160'(0));
    chk("t5_mem_read", mem_read, 1'b0);
    chk("t5_eoc", fetch_eoc, 1'b1);
    // 6: reset while waiting for word 4
    launch(32'h5000, 32'h5100);
    begin
      bit hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
        @(posedge clk);
        #1 hit = (rd_idx - rd_base) == 5;
      end
      if (!hit) begin
        n_chk++; n_fail++;
        $display("FAIL t6_reach_k4: got no fifth read within 200 cycles, expected one");
      end
    end
    reset = 1;
    exp_addr.delete();
    exp_res.delete();
    #1;
    chk("t6_rst_mem_read", mem_read, 1'b0);
    chk("t6_rst_eoc", fetch_eoc, 1'b1);
    chk("t6_rst_vertexes", pack_fv(), 144'h0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    inject_req++;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_stray_vertexes", pack_fv(), 144'h0);
    chk("t6_stray_color", fetch_color, 16'h0);
    chk("t6_stray_eoc", fetch_eoc, 1'b1);
    chk("t6_stray_mem_read", mem_read, 1'b0);
    launch(32'h6000, 32'h6100);
    wait_done("t6");
    chk("t6_read_count", 160'(rd_idx - rd_base), 160'(10));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
